// File: rtl/max_mux_spi_ctrl.sv
// SPI controller for the MAX analog switch matrix. It takes four request channels, arbitrates
// them round-robin, and shifts one 32-bit switch word per transfer on that channel's chip select.
module max_mux_spi_ctrl #(
    parameter int SIFREV  = 2,
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    output logic [3:0]  req_ready,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_en,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic [3:0]  spi_cs_n,
    output logic        busy,
    output logic        done,
    output logic [1:0]  done_chan,
    output logic [31:0] last_word
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      pend_valid_q, pend_valid_d;
    logic [3:0][3:0] pend_addr_q, pend_addr_d;
    logic [3:0]      pend_en_q, pend_en_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [1:0]      chan_q, chan_d;
    logic [31:0]     shreg_q, shreg_d;
    logic [31:0]     word_q, word_d;
    logic [31:0]     last_word_q, last_word_d;
    logic [3:0]      cs_n_q, cs_n_d;
    logic            sclk_q, sclk_d;
    logic [7:0]      div_cnt_q, div_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic            done_q, done_d;
    logic [1:0]      done_chan_q, done_chan_d;
    logic            gnt_found;
    logic [1:0]      gnt_idx, scan_idx;

    // The board revision decides which COM half carries the closed switch.
    function automatic logic [31:0] build_word(input logic [3:0] addr, input logic en);
        logic [15:0] onehot;
        onehot = 16'h1 << addr;
        if (!en)          return 32'h0;
        if (SIFREV == 2)  return {~onehot, onehot};
        if (SIFREV == 3)  return {onehot, ~onehot};
        return 32'h0;
    endfunction

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (!gnt_found && pend_valid_q[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path infers a latch.
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_en_d    = pend_en_q;
        rr_ptr_d     = rr_ptr_q;
        chan_d       = chan_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        last_word_d  = last_word_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        div_cnt_d    = div_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        done_d       = 1'b0;
        done_chan_d  = done_chan_q;

        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && !pend_valid_q[i]) begin
                pend_valid_d[i] = 1'b1;
                pend_addr_d[i]  = req_addr[4*i +: 4];
                pend_en_d[i]    = req_en[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    pend_valid_d[gnt_idx] = 1'b0;
                    rr_ptr_d  = gnt_idx + 2'd1;
                    chan_d    = gnt_idx;
                    word_d    = build_word(pend_addr_q[gnt_idx], pend_en_q[gnt_idx]);
                    shreg_d   = word_d;
                    cs_n_d    = ~(4'b0001 << gnt_idx);
                    sclk_d    = 1'b0;
                    div_cnt_d = 8'd0;
                    bit_cnt_d = 5'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt_q == 8'(CLK_DIV - 1)) begin
                    div_cnt_d = 8'd0;
                    sclk_d    = ~sclk_q;
                    // The falling edge is the only place mosi advances.
                    if (sclk_q) begin
                        if (bit_cnt_q == 5'd31) begin
                            state_d = HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            shreg_d   = {shreg_q[30:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            HOLD: begin
                if (div_cnt_q == 8'(CLK_DIV - 1)) begin
                    cs_n_d      = 4'hF;
                    done_d      = 1'b1;
                    done_chan_d = chan_q;
                    last_word_d = word_q;
                    gap_cnt_d   = 8'd0;
                    state_d     = GAP;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'(CS_GAP - 1)) state_d = IDLE;
                else                             gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pend_valid_q <= 4'h0;
            pend_addr_q  <= '0;
            pend_en_q    <= 4'h0;
            rr_ptr_q     <= 2'd0;
            chan_q       <= 2'd0;
            shreg_q      <= 32'h0;
            word_q       <= 32'h0;
            last_word_q  <= 32'h0;
            cs_n_q       <= 4'hF;
            sclk_q       <= 1'b0;
            div_cnt_q    <= 8'd0;
            gap_cnt_q    <= 8'd0;
            bit_cnt_q    <= 5'd0;
            done_q       <= 1'b0;
            done_chan_q  <= 2'd0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_en_q    <= pend_en_d;
            rr_ptr_q     <= rr_ptr_d;
            chan_q       <= chan_d;
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            last_word_q  <= last_word_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            done_q       <= done_d;
            done_chan_q  <= done_chan_d;
        end
    end

    assign req_ready = ~pend_valid_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = shreg_q[31];
    assign spi_cs_n  = cs_n_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign done_chan = done_chan_q;
    assign last_word = last_word_q;
endmodule

// File: tb/tb_max_mux_spi_ctrl.sv
// Directed bench for max_mux_spi_ctrl: one SIFREV=2 and one SIFREV=3 instance share the request
// inputs; transfers are decoded from the SPI pins and compared with hand-computed words.
module tb_max_mux_spi_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [3:0]  req_en;

    logic [3:0]  req_ready, req_ready3;
    logic        sclk, sclk3, mosi, mosi3, busy, busy3, done, done3;
    logic [3:0]  cs_n, cs_n3;
    logic [1:0]  done_chan, done_chan3;
    logic [31:0] last_word, last_word3;

    int   n_total = 0;
    int   n_bad   = 0;
    int   viol    = 0;
    int   done_cnt = 0;
    logic use3 = 1'b0;

    logic [3:0]  m_cs_n;
    logic        m_sclk, m_mosi, m_busy, m_done;
    logic [1:0]  m_done_chan;
    logic [31:0] m_last_word;

    max_mux_spi_ctrl #(.SIFREV(2), .CLK_DIV(4), .CS_GAP(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_en(req_en), .spi_sclk(sclk), .spi_mosi(mosi),
        .spi_cs_n(cs_n), .busy(busy), .done(done), .done_chan(done_chan),
        .last_word(last_word)
    );

    max_mux_spi_ctrl #(.SIFREV(3), .CLK_DIV(4), .CS_GAP(2)) dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
        .req_addr(req_addr), .req_en(req_en), .spi_sclk(sclk3), .spi_mosi(mosi3),
        .spi_cs_n(cs_n3), .busy(busy3), .done(done3), .done_chan(done_chan3),
        .last_word(last_word3)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_cs_n      = use3 ? cs_n3      : cs_n;
        m_sclk      = use3 ? sclk3      : sclk;
        m_mosi      = use3 ? mosi3      : mosi;
        m_busy      = use3 ? busy3      : busy;
        m_done      = use3 ? done3      : done;
        m_done_chan = use3 ? done_chan3 : done_chan;
        m_last_word = use3 ? last_word3 : last_word;
    end

    // Bus-level invariants on both instances: one chip select at most, sclk parked when idle.
    always @(negedge clk) begin
        if ($countones(~cs_n) > 1 || $countones(~cs_n3) > 1) viol++;
        if ((cs_n == 4'hF && sclk) || (cs_n3 == 4'hF && sclk3)) viol++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] v, input logic [15:0] a, input logic [3:0] e);
        req_valid = v;
        req_addr  = a;
        req_en    = e;
        @(negedge clk);
        req_valid = 4'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (m_busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", 32'(t < 3000), 32'd1);
    endtask

    // Waits for a chip select, then decodes the word on sclk rises until all cs_n are high.
    task automatic capture(output logic [1:0] chan, output logic [31:0] word,
                           output int low_cyc, output int gap);
        int   t;
        logic prev_sclk;
        chan = 2'd0; word = 32'h0; low_cyc = 0; t = 0; prev_sclk = 1'b0;
        while (m_cs_n == 4'hF && t < 2000) begin
            @(negedge clk);
            t++;
        end
        gap = t;
        check("cs_wait", 32'(t < 2000), 32'd1);
        for (int i = 0; i < 4; i++) if (!m_cs_n[i]) chan = 2'(i);
        while (m_cs_n != 4'hF && low_cyc < 2000) begin
            low_cyc++;
            if (m_sclk && !prev_sclk) word = {word[30:0], m_mosi};
            prev_sclk = m_sclk;
            @(negedge clk);
        end
    endtask

    logic [1:0]  c;
    logic [31:0] w;
    int          lc, gp, t, rises, base;
    logic [1:0]  exp_chan [4];
    logic [31:0] exp_word [4];

    initial begin
        rst = 1'b1; req_valid = 4'h0; req_addr = 16'h0; req_en = 4'h0;
        @(negedge clk);
        check("rst_cs_n",   32'(cs_n),      32'hF);
        check("rst_sclk",   32'(sclk),      32'd0);
        check("rst_mosi",   32'(mosi),      32'd0);
        check("rst_busy",   32'(busy),      32'd0);
        check("rst_done",   32'(done),      32'd0);
        check("rst_dchan",  32'(done_chan), 32'd0);
        check("rst_lword",  last_word,      32'h0);
        check("rst_ready",  32'(req_ready), 32'hF);
        rst = 1'b0;
        @(negedge clk);

        // TX1, addr 5, SIFREV=2: minimum latency, 260-cycle CS, word 0xFFDF0020.
        send(4'b0001, 16'h0005, 4'b0001);
        check("lat_cs_hi",  32'(cs_n),      32'hF);
        check("lat_ready",  32'(req_ready), 32'hE);
        @(negedge clk);
        check("lat_cs_lo",  32'(cs_n),      32'hE);
        check("lat_busy",   32'(busy),      32'd1);
        capture(c, w, lc, gp);
        check("t1_chan",    32'(c),         32'd0);
        check("t1_word",    w,              32'hFFDF0020);
        check("t1_low",     32'(lc),        32'd260);
        check("t1_done",    32'(done),      32'd1);
        check("t1_dchan",   32'(done_chan), 32'd0);
        check("t1_lword",   last_word,      32'hFFDF0020);
        @(negedge clk);
        check("t1_done_off", 32'(done),     32'd0);

        // RX2, addr 0, SIFREV=3 instance: enabled then disabled.
        use3 = 1'b1;
        wait_idle();
        send(4'b1000, 16'h0000, 4'b1000);
        capture(c, w, lc, gp);
        check("r3_chan",    32'(c),           32'd3);
        check("r3_word",    w,                32'h0001FFFE);
        check("r3_done",    32'(done3),       32'd1);
        check("r3_dchan",   32'(done_chan3),  32'd3);
        check("r3_lword",   last_word3,       32'h0001FFFE);
        wait_idle();
        send(4'b1000, 16'h0000, 4'b0000);
        capture(c, w, lc, gp);
        check("r3_off_word",  w,              32'h0);
        check("r3_off_lword", last_word3,     32'h0);
        use3 = 1'b0;
        wait_idle();

        // All four channels at once after reset: served 0,1,2,3 with a CS gap in between.
        do_reset();
        exp_chan = '{2'd0, 2'd1, 2'd2, 2'd3};
        exp_word = '{32'h7FFF8000, 32'hFEFF0100, 32'hFFFD0002, 32'hFBFF0400};
        send(4'hF, 16'hA18F, 4'hF);
        for (int k = 0; k < 4; k++) begin
            capture(c, w, lc, gp);
            check($sformatf("rr_chan%0d", k), 32'(c), 32'(exp_chan[k]));
            check($sformatf("rr_word%0d", k), w,      exp_word[k]);
            if (k > 0) check($sformatf("rr_gap%0d", k), 32'(gp >= 2), 32'd1);
        end
        wait_idle();

        // Channel 1 pending behind channel 0; its second request waits for the channel 1 grant.
        req_valid = 4'b0011; req_addr = 16'h0072; req_en = 4'b0011;
        @(negedge clk);
        req_valid = 4'b0010;
        check("pend_ready", 32'(req_ready), 32'hC);
        capture(c, w, lc, gp);
        check("pend_chan0", 32'(c), 32'd0);
        check("pend_word0", w,      32'hFFFB0004);
        check("pend_rdy1_busy", 32'(req_ready[1]), 32'd0);
        t = 0;
        while (cs_n[1] && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("pend_grant1", 32'(t < 100), 32'd1);
        check("pend_rdy1_grant", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        check("pend_rdy1_acc", 32'(req_ready[1]), 32'd0);
        req_valid = 4'h0;
        t = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("pend_done1",  32'(done),      32'd1);
        check("pend_dchan1", 32'(done_chan), 32'd1);
        check("pend_lword1", last_word,      32'hFF7F0080);
        capture(c, w, lc, gp);
        check("pend_chan1b", 32'(c), 32'd1);
        check("pend_word1b", w,      32'hFF7F0080);
        wait_idle();

        // Reset during bit 10 of an RX1 transfer, then a fresh request completes.
        send(4'b0100, 16'h0300, 4'b0100);
        rises = 0; t = 0;
        while (rises < 10 && t < 400) begin
            logic ps;
            ps = sclk;
            @(negedge clk);
            if (sclk && !ps && cs_n != 4'hF) rises++;
            t++;
        end
        check("abort_rises", 32'(rises), 32'd10);
        @(negedge clk);
        base = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("abort_cs_n",  32'(cs_n),      32'hF);
        check("abort_sclk",  32'(sclk),      32'd0);
        check("abort_mosi",  32'(mosi),      32'd0);
        check("abort_busy",  32'(busy),      32'd0);
        check("abort_ready", 32'(req_ready), 32'hF);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(base));
        check("abort_lword",   last_word,     32'h0);
        send(4'b0010, 16'h00C0, 4'b0010);
        capture(c, w, lc, gp);
        check("fresh_chan",  32'(c),         32'd1);
        check("fresh_word",  w,              32'hEFFF1000);
        check("fresh_low",   32'(lc),        32'd260);
        check("fresh_dchan", 32'(done_chan), 32'd1);
        wait_idle();

        // Pointer wrap: after a grant to channel 3, channel 0 beats channel 3.
        send(4'b1000, 16'h5000, 4'b1000);
        capture(c, w, lc, gp);
        check("wrap_first", 32'(c), 32'd3);
        wait_idle();
        send(4'b1001, 16'h9004, 4'b1001);
        capture(c, w, lc, gp);
        check("wrap_chan0", 32'(c), 32'd0);
        check("wrap_word0", w,      32'hFFEF0010);
        capture(c, w, lc, gp);
        check("wrap_chan3", 32'(c), 32'd3);
        check("wrap_word3", w,      32'hFDFF0200);
        wait_idle();

        check("bus_invariants", 32'(viol), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/max_mux_spi_ctrl.md
MAX_MUX_SPI_CTRL -- requirements
Module: max_mux_spi_ctrl

Interface
REQ-001 Parameter SIFREV, default 2, board revision: 2 means COMB is grounded and COMA carries signals; 3 means COMA is grounded and COMB carries signals.
REQ-002 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 2..255.
REQ-003 Parameter CS_GAP, default 2, minimum number of idle clk cycles with all cs_n high between transfers; legal range 1..255.
REQ-004 Port clk, input, 1 bit: the single clock; all logic rises on its posedge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port req_valid, input, 4 bits: per-channel request; channel 0=TX1, 1=TX2, 2=RX1, 3=RX2.
REQ-007 Port req_ready, output, 4 bits: per-channel accept; a request transfers when req_valid[i] and req_ready[i] are both high at a posedge.
REQ-008 Port req_addr, input, 16 bits: channel i route address (0-15) on bits [4i+3:4i].
REQ-009 Port req_en, input, 4 bits: 1 connects the addressed route; 0 opens all 32 switches.
REQ-010 Port spi_sclk, output, 1 bit: SPI clock, mode 0.
REQ-011 Port spi_mosi, output, 1 bit: SPI data, sent MSB first.
REQ-012 Port spi_cs_n, output, 4 bits: active-low chip selects, one per channel.
REQ-013 Port busy, output, 1 bit: high while the FSM is outside IDLE.
REQ-014 Port done, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-015 Port done_chan, output, 2 bits: channel of the completed transfer; valid only while done is high.
REQ-016 Port last_word, output, 32 bits: the word most recently shifted out.

Function
REQ-017 Each channel SHALL have a pending register holding valid, addr and en; req_ready[i] = ~pending_valid[i], combinational from the register only.
REQ-018 On acceptance, the pending register SHALL capture addr and en on that edge; pending_valid[i] SHALL clear on the edge the FSM leaves IDLE granting channel i.
REQ-019 The word SHALL be built from onehot = 1<<addr (16 bits); en=1 with SIFREV=2 gives {~onehot, onehot}; en=1 with SIFREV=3 gives {onehot, ~onehot}; en=0 gives 32'h0; any other SIFREV gives 32'h0.
REQ-020 The arbiter SHALL be round-robin: search starts at rr_ptr and wraps 3->0; after a grant to channel g, rr_ptr = (g+1) mod 4.
REQ-021 FSM states SHALL be IDLE, SHIFT, HOLD and GAP.
REQ-022 IDLE -> SHIFT SHALL occur when any pending_valid is set: load the shift register with the word, assert spi_cs_n[g] low, drive spi_mosi = word[31], spi_sclk = 0.
REQ-023 In SHIFT, each bit SHALL take 2*CLK_DIV cycles: CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
REQ-024 spi_mosi SHALL change only on the cycle sclk falls to begin the next bit.
REQ-025 After the 32nd high phase, the FSM SHALL go to HOLD: sclk low, cs_n still low, for CLK_DIV cycles.
REQ-026 HOLD -> GAP SHALL deassert all cs_n, pulse done with done_chan = g, and update last_word; the CS low time is exactly 65*CLK_DIV cycles.
REQ-027 GAP SHALL last CS_GAP cycles, then return to IDLE.
REQ-028 A request arriving on a channel while that channel is mid-transfer SHALL be accepted (its pending register is already clear) and served in a later transfer.
REQ-029 Simultaneous requests SHALL be served one per transfer in round-robin order.
REQ-030 At most one spi_cs_n bit SHALL be low at any time.
REQ-031 spi_sclk SHALL be 0 whenever all cs_n are high.
REQ-032 Minimum latency: acceptance at edge N gives cs_n low after edge N+1 when IDLE and that channel wins arbitration.

Reset
REQ-033 While rst is high, all state SHALL be forced asynchronously: FSM = IDLE, all pending_valid = 0, rr_ptr = 0, spi_cs_n = 4'hF, spi_sclk = 0, spi_mosi = 0, busy = 0, done = 0, done_chan = 0, last_word = 32'h0, req_ready = 4'hF.
REQ-034 Reset mid-transfer SHALL abort the transfer with no done pulse; the aborted request is lost.

Verification
REQ-035 SIFREV=2, TX1 addr=5, en=1 -> spi_cs_n[0] low for 260 cycles (CLK_DIV=4); bits sampled on sclk rise = 0xFFDF0020; done with done_chan=0; last_word=0xFFDF0020.
REQ-036 SIFREV=3, RX2 addr=0, en=1 -> spi_cs_n[3] carries 0x0001FFFE; with en=0 -> 0x00000000.
REQ-037 All four channels valid in the same cycle after reset -> transfers in order 0,1,2,3; gap between cs_n edges >= CS_GAP; never two cs_n low.
REQ-038 Channel 1 pending while channel 0 transfers; a second channel 1 request -> req_ready[1]=0 until the channel 1 grant, then 1.
REQ-039 rst pulsed during bit 10 of a transfer -> cs_n=4'hF, sclk=0, mosi=0 in the same cycle; no done pulse; a fresh request after reset completes normally.
REQ-040 Wrap check: last grant = channel 3, then channels 0 and 3 both requesting -> channel 0 is served first.
